// File: rtl/keypad_entry_if.sv
// Entry-word bus from the keypad scanner to the calculator core.
// Combinational bundle of wires; it adds no latency.
// No backpressure: the sink must take o_key_valid pulses as they come.
interface keypad_entry_if;
    logic        i_clear;
    logic [15:0] o_data;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic [2:0]  o_digit_count;

    modport master (
        input  i_clear,
        output o_data,
        output o_key_valid,
        output o_key_code,
        output o_digit_count
    );

    modport slave (
        output i_clear,
        input  o_data,
        input  o_key_valid,
        input  o_key_code,
        input  o_digit_count
    );
endinterface

// File: rtl/keypad_entry.sv
// Scans a 4x4 hex keypad, debounces presses and shifts hex digits into a 16-bit word.
// Latency: o_key_valid fires N_debouncer+3 edges after the row pins first sample low.
// No backpressure: one o_key_valid pulse per accepted key, which the sink cannot stall.
module keypad_entry #(
    parameter int N_debouncer = 10,
    parameter int SCAN_DIV    = 1000
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic [3:0]     i_rows,
    output logic [3:0]     o_cols,
    keypad_entry_if.master ent
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(N_debouncer + 1);
    localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_TC  = DW'(N_debouncer - 1);

    typedef enum logic [2:0] {
        SCAN      = 3'd0,
        DEBOUNCE  = 3'd1,
        ACCEPT    = 3'd2,
        RELEASE   = 3'd3,
        RDEBOUNCE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    rows_meta;
    logic [3:0]    rs;
    logic [3:0]    cols;
    logic [3:0]    pat;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] deb_cnt;
    logic [3:0]    key_code;
    logic [15:0]   data;
    logic [2:0]    count;
    logic          key_valid;

    // Lowest-index low row and the driven column select the key.
    function automatic logic [3:0] decode(input logic [3:0] rows, input logic [3:0] c_drv);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        r    = 2'd0;
        c    = 2'd0;
        code = 4'h0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i])  r = 2'(i);
            if (!c_drv[i]) c = 2'(i);
        end
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Rows idle high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rows_meta <= 4'hF;
            rs        <= 4'hF;
        end else begin
            rows_meta <= i_rows;
            rs        <= rows_meta;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= SCAN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:      if (rs != 4'hF) state_nxt = DEBOUNCE;
            DEBOUNCE:  if (rs != pat) state_nxt = SCAN;
                       else if (deb_cnt == DEB_TC) state_nxt = ACCEPT;
            ACCEPT:    state_nxt = RELEASE;
            RELEASE:   if (rs == 4'hF) state_nxt = RDEBOUNCE;
            RDEBOUNCE: if (rs != 4'hF) state_nxt = RELEASE;
                       else if (deb_cnt == DEB_TC) state_nxt = SCAN;
            default:   state_nxt = SCAN;
        endcase
    end

    always_comb begin
        key_valid = (state == ACCEPT);
    end

    // Scan counter only runs in SCAN; any other state parks it at 0 so a return starts a fresh dwell.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cols     <= 4'b1110;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            pat      <= 4'hF;
            key_code <= 4'h0;
        end else begin
            scan_cnt <= '0;
            case (state)
                SCAN: begin
                    if (rs != 4'hF) begin
                        pat     <= rs;
                        deb_cnt <= '0;
                    end else if (scan_cnt == SCAN_TC) begin
                        cols <= {cols[2:0], cols[3]};
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs == pat) begin
                        if (deb_cnt == DEB_TC) key_code <= decode(pat, cols);
                        else                   deb_cnt  <= deb_cnt + 1'b1;
                    end
                end
                RELEASE: deb_cnt <= '0;
                RDEBOUNCE: begin
                    if (rs == 4'hF && deb_cnt != DEB_TC) deb_cnt <= deb_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear beats a coincident accept; the FSM and key code are unaffected by it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            data  <= 16'h0000;
            count <= 3'd0;
        end else if (ent.i_clear) begin
            data  <= 16'h0000;
            count <= 3'd0;
        end else if (state == ACCEPT) begin
            data <= {data[11:0], key_code};
            if (count != 3'd4) count <= count + 3'd1;
        end
    end

    assign o_cols            = cols;
    assign ent.o_data        = data;
    assign ent.o_key_valid   = key_valid;
    assign ent.o_key_code    = key_code;
    assign ent.o_digit_count = count;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed keypad presses with a scoreboard of expected accepts (code, word, count, cycle).
module tb_keypad_entry;
    localparam int N  = 4;
    localparam int SD = 8;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [3:0] i_rows;
    logic [3:0] o_cols;
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
        logic [2:0]  cnt;
        int          at;
    } exp_t;
    exp_t q[$];

    keypad_entry_if ent();

    keypad_entry #(.N_debouncer(N), .SCAN_DIV(SD)) dut (
        .clk    (clk),
        .resetN (resetN),
        .i_rows (i_rows),
        .o_cols (o_cols),
        .ent    (ent.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: the pressed key pulls its row low only while its column is driven.
    assign i_rows = (key_down && !o_cols[key_c]) ? ~(4'b0001 << key_r) : 4'hF;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] d, input logic [2:0] n, input int at);
        exp_t e;
        e.code = c;
        e.data = d;
        e.cnt  = n;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic wait_col(input logic [3:0] m);
        logic [3:0] prev;
        bit done;
        prev = o_cols;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (o_cols == m && prev != m) done = 1'b1;
            prev = o_cols;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_col actual=%b required=%b", o_cols, m);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c, output int t0);
        logic [3:0] m;
        m = ~(4'b0001 << c);
        key_r = r;
        key_c = c;
        wait_col(m);
        key_down = 1'b1;
        t0 = cyc;
    endtask

    task automatic release_key(input int hold);
        repeat (hold) @(negedge clk);
        key_down = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic enter(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code,
                         input logic [15:0] d, input logic [2:0] n);
        int t0;
        press(r, c, t0);
        push(code, d, n, t0 + N + 3);
        release_key(30);
    endtask

    task automatic check_reset_vals();
        check("rst_cols",  32'(o_cols), 32'hE);
        check("rst_data",  32'(ent.o_data), 32'h0);
        check("rst_valid", 32'(ent.o_key_valid), 32'h0);
        check("rst_code",  32'(ent.o_key_code), 32'h0);
        check("rst_count", 32'(ent.o_digit_count), 32'h0);
    endtask

    // Monitor: every valid pulse must match the head of the queue; word/count are checked next cycle.
    initial begin
        exp_t cur;
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("sb_data",  32'(ent.o_data), 32'(cur.data));
                check("sb_count", 32'(ent.o_digit_count), 32'(cur.cnt));
                pend = 1'b0;
            end
            if (resetN && ent.o_key_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%0h required=none", ent.o_key_code);
                end else begin
                    cur = q.pop_front();
                    check("sb_code", 32'(ent.o_key_code), 32'(cur.code));
                    if (cur.at >= 0) check("sb_latency", cyc, cur.at);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int last;
        logic [3:0] rot_exp [4];
        rot_exp[0] = 4'b1101; rot_exp[1] = 4'b1011; rot_exp[2] = 4'b0111; rot_exp[3] = 4'b1110;
        ent.i_clear = 1'b0;

        #1 resetN = 1'b0;
        #20 check_reset_vals();
        @(negedge clk);
        resetN = 1'b1;
        last = cyc;

        // Idle scan: each column is held for SD cycles.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] prev;
            prev = o_cols;
            for (int n = 0; n < 50 && o_cols == prev; n++) @(negedge clk);
            check("rot_cols", 32'(o_cols), 32'(rot_exp[i]));
            check("rot_period", cyc - last, SD);
            last = cyc;
        end

        // '5' at r1,c1, held 40 cycles.
        press(2'd1, 2'd1, t0);
        push(4'h5, 16'h0005, 3'd1, t0 + N + 3);
        release_key(40);

        // Plain clear away from any accept.
        @(negedge clk);
        ent.i_clear = 1'b1;
        @(negedge clk);
        ent.i_clear = 1'b0;
        check("clr_data",  32'(ent.o_data), 32'h0);
        check("clr_count", 32'(ent.o_digit_count), 32'h0);

        enter(2'd0, 2'd0, 4'h1, 16'h0001, 3'd1);
        enter(2'd0, 2'd1, 4'h2, 16'h0012, 3'd2);
        enter(2'd0, 2'd3, 4'hA, 16'h012A, 3'd3);
        enter(2'd3, 2'd1, 4'hF, 16'h12AF, 3'd4);
        enter(2'd0, 2'd2, 4'h3, 16'h2AF3, 3'd4);

        // Contact bounce on '7' (r2,c0): 2 low / 2 high for 20 cycles, then stable low.
        key_r = 2'd2;
        key_c = 2'd0;
        wait_col(4'b1110);
        for (int k = 0; k < 5; k++) begin
            key_down = 1'b1;
            repeat (2) @(negedge clk);
            key_down = 1'b0;
            repeat (2) @(negedge clk);
        end
        key_down = 1'b1;
        push(4'h7, 16'hAF37, 3'd4, cyc + N + 3);
        release_key(30);

        // 'B' (r1,c3) held 200 cycles, release bounces high 2 / low 1 / high.
        press(2'd1, 2'd3, t0);
        push(4'hB, 16'hF37B, 3'd4, t0 + N + 3);
        repeat (200) @(negedge clk);
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        key_down = 1'b1;
        @(negedge clk);
        key_down = 1'b0;
        t0 = cyc;
        for (int n = 0; n < 100 && o_cols == 4'b0111; n++) @(negedge clk);
        check("rel_rescan_cyc", cyc, t0 + N + 3 + SD);
        repeat (20) @(negedge clk);

        // 'D' (r3,c3) with clear coincident with the accept cycle.
        press(2'd3, 2'd3, t0);
        push(4'hD, 16'h0000, 3'd0, t0 + N + 3);
        repeat (N + 3) @(negedge clk);
        ent.i_clear = 1'b1;
        @(negedge clk);
        ent.i_clear = 1'b0;
        release_key(30);

        // Reset while '5' is mid-debounce, then the held key is accepted once from SCAN.
        enter(2'd2, 2'd2, 4'h9, 16'h0009, 3'd1);
        press(2'd1, 2'd1, t0);
        repeat (5) @(negedge clk);
        resetN = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        push(4'h5, 16'h0005, 3'd1, -1);
        resetN = 1'b1;
        release_key(60);
        repeat (10) @(negedge clk);

        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Input-side counterpart of the calculator's display path. The display path turns the 16-bit binary value into scanned 7-segment digits. This block scans a 4x4 hex matrix keypad, debounces each key press and assembles the hex digits into the 16-bit operand word that feeds the calculator's DataIn. It sits beside the calculator core at the board top level, in the same clock domain.

Parameters:
N_debouncer, 10, consecutive stable cycles required to accept a press or a release
SCAN_DIV, 1000, clock cycles each column stays driven while scanning (>=2)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous reset, active-low
i_rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clk
i_clear  input  1  synchronous clear of the entry word, active-high, level
o_cols  output  4  keypad column drive, active-low, one-hot-low
o_data  output  16  assembled entry word; newest digit in [3:0]
o_key_valid  output  1  one-cycle pulse per accepted key
o_key_code  output  4  hex value of the last accepted key
o_digit_count  output  3  digits entered since clear, saturates at 4

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on resetN. All flops clear on resetN low.
- Reset values: o_cols=4'b1110 (col0 driven), o_data=0, o_key_valid=0, o_key_code=0, o_digit_count=0, state SCAN, all counters 0.
- i_rows passes through a 2-flop synchronizer. The FSM uses only the synced value, rs.
- Key map (row r, col c). r0: 1 2 3 A. r1: 4 5 6 B. r2: 7 8 9 C. r3: 0 F E D.
- If more than one row is low, the lowest-index low row wins.
- FSM states: SCAN, DEBOUNCE, ACCEPT, RELEASE, RDEBOUNCE.
- SCAN:
  - The scan counter counts 0..SCAN_DIV-1.
  - At terminal count, o_cols rotates to the next column (1110->1101->1011->0111->1110) and the counter returns to 0.
  - If rs != 4'hF, latch the pattern, clear the debounce counter and go to DEBOUNCE. The column is frozen.
- DEBOUNCE:
  - If rs equals the latched pattern, the counter increments. When it reaches N_debouncer-1, go to ACCEPT.
  - If rs differs, return to SCAN. The column is kept and the scan counter resets to 0.
- ACCEPT (exactly 1 cycle):
  - o_key_valid=1 and o_key_code=decoded key.
  - o_data <= {o_data[11:0], code}.
  - o_digit_count <= min(count+1, 4).
  - Go to RELEASE.
- Latency: o_key_valid is high exactly N_debouncer+3 rising edges after the first edge that samples the row pins low, provided the pins stay stable. Breakdown: 2 sync + 1 detect + N_debouncer.
- RELEASE: wait for rs==4'hF, then clear the counter and go to RDEBOUNCE.
- RDEBOUNCE:
  - rs==4'hF for N_debouncer consecutive cycles returns to SCAN, with the column kept and the scan counter at 0.
  - Any low row returns to RELEASE.
  - A held key therefore produces exactly one o_key_valid, with no autorepeat.
- Overflow: beyond 4 digits, the oldest nibble shifts out of [15:12]. o_digit_count stays 4.
- i_clear: o_data<=0 and o_digit_count<=0 on the next edge. The FSM is not affected.
  - If i_clear is high in the ACCEPT cycle, clear wins: o_data=0, count=0, and no shift occurs.
  - o_key_valid still pulses and o_key_code still updates.
- o_key_valid is low in every state except ACCEPT.
- resetN asserted mid-debounce or mid-hold:
  - All state returns to the reset values immediately.
  - After release of reset, a key still held is seen as a new press from SCAN once col0 is back on its column. It is accepted once.

Test Plan:
- Reset mid-operation: hold key while resetN pulses low during DEBOUNCE -> outputs immediately take reset values. After release, exactly one accept occurs once col0 reaches that key's column.
- N_debouncer=4, SCAN_DIV=8; model presses '5' (r1,c1) when o_cols=1101, held 40 cycles -> one o_key_valid exactly 7 edges after rows go low; o_key_code=5; o_data=16'h0005; o_digit_count=1.
- Enter 1,2,A,F,3 in sequence -> o_data passes through 0001, 0012, 012A, 12AF, then 2AF3; o_digit_count ends at 4.
- Bounce: rows toggle low/high every 2 cycles for 20 cycles, then stable low -> no accept during bouncing; exactly one accept after N_debouncer+3 edges of stability.
- Key held 200 cycles with release bounce (high 2, low 1, then high) -> single o_key_valid; FSM returns to SCAN only N_debouncer cycles after the final high.
- Scan rotation: no key -> o_cols cycles 1110,1101,1011,0111 every 8 cycles. i_clear coincident with an ACCEPT for 'D' -> o_data=0, count=0, o_key_code=D, valid pulses.
